// File: rtl/mash_pkg.sv
// Shared types and helpers for the MASH 1-1 noise-cancellation stage.
// Level y spans -1..+2 and maps onto 0..3 active unit elements.
package mash_pkg;

    typedef logic signed [2:0] mash_level_t;
    typedef logic [1:0]        mash_count_t;

    localparam int unsigned MASH_N_ELEM = 3;

    // Number of unit elements to enable for a given output level (y + 1).
    function automatic mash_count_t level_to_count(input mash_level_t level);
        mash_level_t biased;
        biased = level + 3'sd1;
        return biased[1:0];
    endfunction

endpackage

// File: rtl/dwa_rotator.sv
// Data-weighted-averaging element selector: holds the rotation pointer and
// maps an element count onto a rotated thermometer enable word.
module dwa_rotator
    import mash_pkg::*;
#(
    parameter int unsigned N_ELEM = MASH_N_ELEM,
    parameter bit          DWA_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  mash_count_t       count,
    output logic [N_ELEM-1:0] elem
);

    localparam int unsigned PW = $clog2(N_ELEM);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Element i is on when its distance from ptr (mod N_ELEM) is below count.
    always_comb begin
        int unsigned off;
        elem = '0;
        off  = 0;
        for (int unsigned i = 0; i < N_ELEM; i++) begin
            off     = (i + N_ELEM - 32'(ptr_q)) % N_ELEM;
            elem[i] = (off < 32'(count));
        end
    end

    always_comb begin
        int unsigned sum;
        sum = 32'(ptr_q) + 32'(count);
        if (sum >= N_ELEM) begin
            sum = sum - N_ELEM;
        end
        ptr_d = DWA_EN ? PW'(sum) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axis_mash11_ncl.sv
// MASH 1-1 noise cancellation: joins the two EFM carry streams, forms
// y = c1 + c2 - c2[n-1] and registers it with its DWA unit-element word.
module axis_mash11_ncl
    import mash_pkg::*;
#(
    parameter int unsigned N_ELEM = MASH_N_ELEM,
    parameter bit          DWA_EN = 1'b1
) (
    input  logic              aclk,
    input  logic              arst_n,
    input  logic              s_axis_c1_tdata,
    input  logic              s_axis_c1_tvalid,
    output logic              s_axis_c1_tready,
    input  logic              s_axis_c2_tdata,
    input  logic              s_axis_c2_tvalid,
    output logic              s_axis_c2_tready,
    output logic [2:0]        m_axis_data_tdata,
    output logic [N_ELEM-1:0] m_axis_elem_tdata,
    output logic              m_axis_data_tvalid,
    input  logic              m_axis_data_tready
);

    logic              can_load;
    logic              fire;
    mash_level_t       level;
    mash_count_t       count;
    logic [N_ELEM-1:0] elem;

    logic              valid_q, valid_d;
    mash_level_t       data_q, data_d;
    logic [N_ELEM-1:0] elem_q, elem_d;
    logic              c2_d_q, c2_d_d;

    // Output slot is free when empty or draining this cycle.
    assign can_load = !valid_q || m_axis_data_tready;
    assign fire     = s_axis_c1_tvalid && s_axis_c2_tvalid && can_load;

    assign s_axis_c1_tready = s_axis_c2_tvalid && can_load;
    assign s_axis_c2_tready = s_axis_c1_tvalid && can_load;

    assign level = $signed({2'b00, s_axis_c1_tdata})
                 + $signed({2'b00, s_axis_c2_tdata})
                 - $signed({2'b00, c2_d_q});
    assign count = level_to_count(level);

    dwa_rotator #(
        .N_ELEM (N_ELEM),
        .DWA_EN (DWA_EN)
    ) u_dwa (
        .clk   (aclk),
        .rst_n (arst_n),
        .en    (fire),
        .count (count),
        .elem  (elem)
    );

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        elem_d  = elem_q;
        c2_d_d  = c2_d_q;
        if (fire) begin
            valid_d = 1'b1;
            data_d  = level;
            elem_d  = elem;
            c2_d_d  = s_axis_c2_tdata;
        end else if (m_axis_data_tready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            elem_q  <= '0;
            c2_d_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            elem_q  <= elem_d;
            c2_d_q  <= c2_d_d;
        end
    end

    assign m_axis_data_tvalid = valid_q;
    assign m_axis_data_tdata  = data_q;
    assign m_axis_elem_tdata  = elem_q;

endmodule

// File: tb/tb_axis_mash11_ncl.sv
// Directed bench for axis_mash11_ncl: a DWA instance and a static-thermometer
// instance share the same input streams.
module tb_axis_mash11_ncl;

    logic       aclk = 1'b0;
    logic       arst_n = 1'b0;
    logic       c1_data = 1'b0;
    logic       c1_valid = 1'b0;
    logic       c2_data = 1'b0;
    logic       c2_valid = 1'b0;
    logic       m_ready = 1'b0;

    logic       c1_ready, c2_ready, m_valid;
    logic [2:0] m_data, m_elem;
    logic       c1_ready_s, c2_ready_s, m_valid_s;
    logic [2:0] m_data_s, m_elem_s;

    int checks = 0;
    int errors = 0;

    // Expected results for the beats (1,1),(0,0),(1,0),(0,1) from reset.
    logic [2:0] exp_y  [4] = '{3'b010, 3'b111, 3'b001, 3'b001};
    logic [2:0] exp_e  [4] = '{3'b111, 3'b000, 3'b011, 3'b101};
    logic [2:0] exp_es [4] = '{3'b111, 3'b000, 3'b011, 3'b011};
    logic       seq_c1 [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       seq_c2 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 aclk = ~aclk;

    axis_mash11_ncl #(.N_ELEM(3), .DWA_EN(1'b1)) dut (
        .aclk               (aclk),
        .arst_n             (arst_n),
        .s_axis_c1_tdata    (c1_data),
        .s_axis_c1_tvalid   (c1_valid),
        .s_axis_c1_tready   (c1_ready),
        .s_axis_c2_tdata    (c2_data),
        .s_axis_c2_tvalid   (c2_valid),
        .s_axis_c2_tready   (c2_ready),
        .m_axis_data_tdata  (m_data),
        .m_axis_elem_tdata  (m_elem),
        .m_axis_data_tvalid (m_valid),
        .m_axis_data_tready (m_ready)
    );

    axis_mash11_ncl #(.N_ELEM(3), .DWA_EN(1'b0)) dut_s (
        .aclk               (aclk),
        .arst_n             (arst_n),
        .s_axis_c1_tdata    (c1_data),
        .s_axis_c1_tvalid   (c1_valid),
        .s_axis_c1_tready   (c1_ready_s),
        .s_axis_c2_tdata    (c2_data),
        .s_axis_c2_tvalid   (c2_valid),
        .s_axis_c2_tready   (c2_ready_s),
        .m_axis_data_tdata  (m_data_s),
        .m_axis_elem_tdata  (m_elem_s),
        .m_axis_data_tvalid (m_valid_s),
        .m_axis_data_tready (m_ready)
    );

    task automatic pulse_reset();
        @(negedge aclk);
        c1_valid = 1'b0;
        c2_valid = 1'b0;
        arst_n   = 1'b0;
        @(negedge aclk);
        arst_n   = 1'b1;
    endtask

    task automatic set_beat(input logic c1, input logic c2);
        c1_data  = c1;
        c2_data  = c2;
        c1_valid = 1'b1;
        c2_valid = 1'b1;
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        arst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge aclk);
            #1;
            checks++;
            if ({m_valid, m_data, m_elem, c1_ready, c2_ready} !== 9'b0) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: valid=%b data=%b elem=%b rdy=%b%b want all 0",
                         i, m_valid, m_data, m_elem, c1_ready, c2_ready);
            end
            checks++;
            if ({m_valid_s, m_elem_s, c1_ready_s, c2_ready_s} !== 6'b0) begin
                errors++;
                $display("FAIL reset_idle_static cyc %0d: valid=%b elem=%b want 0",
                         i, m_valid_s, m_elem_s);
            end
        end
    endtask

    task automatic test_sequence();
        pulse_reset();
        m_ready = 1'b1;
        set_beat(seq_c1[0], seq_c2[0]);
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk);
            #1;
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_y[i] || m_elem !== exp_e[i]) begin
                errors++;
                $display("FAIL seq beat %0d: valid=%b y=%b elem=%b want 1 y=%b elem=%b",
                         i, m_valid, m_data, m_elem, exp_y[i], exp_e[i]);
            end
            checks++;
            if (m_data_s !== exp_y[i] || m_elem_s !== exp_es[i]) begin
                errors++;
                $display("FAIL seq_static beat %0d: y=%b elem=%b want y=%b elem=%b",
                         i, m_data_s, m_elem_s, exp_y[i], exp_es[i]);
            end
            if (i < 3) set_beat(seq_c1[i+1], seq_c2[i+1]);
            else begin
                c1_valid = 1'b0;
                c2_valid = 1'b0;
            end
        end
        checks++;
        if (dut.u_dwa.ptr_q !== 2'd1 || dut_s.u_dwa.ptr_q !== 2'd0) begin
            errors++;
            $display("FAIL seq_ptr: ptr=%0d static=%0d want 1 and 0",
                     dut.u_dwa.ptr_q, dut_s.u_dwa.ptr_q);
        end
        @(posedge aclk);
        #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_drain: valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_stall();
        pulse_reset();
        m_ready = 1'b0;
        set_beat(1'b1, 1'b1);
        @(posedge aclk);
        #1;
        set_beat(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 3'b010 || m_elem !== 3'b111 ||
                c1_ready !== 1'b0 || c2_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc %0d: valid=%b y=%b elem=%b rdy=%b%b want 1 010 111 00",
                         i, m_valid, m_data, m_elem, c1_ready, c2_ready);
            end
            @(posedge aclk);
            #1;
        end
        m_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            @(posedge aclk);
            #1;
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp_y[i] || m_elem !== exp_e[i]) begin
                errors++;
                $display("FAIL stall_resume beat %0d: valid=%b y=%b elem=%b want 1 y=%b elem=%b",
                         i, m_valid, m_data, m_elem, exp_y[i], exp_e[i]);
            end
            if (i < 3) set_beat(seq_c1[i+1], seq_c2[i+1]);
            else begin
                c1_valid = 1'b0;
                c2_valid = 1'b0;
            end
        end
    endtask

    task automatic test_join();
        pulse_reset();
        m_ready  = 1'b1;
        c1_data  = 1'b1;
        c1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge aclk);
            #1;
            checks++;
            if (c1_ready !== 1'b0 || c2_ready !== 1'b1 || m_valid !== 1'b0) begin
                errors++;
                $display("FAIL join_wait cyc %0d: c1_rdy=%b c2_rdy=%b valid=%b want 0 1 0",
                         i, c1_ready, c2_ready, m_valid);
            end
        end
        c2_data  = 1'b0;
        c2_valid = 1'b1;
        #1;
        checks++;
        if (c1_ready !== 1'b1 || c2_ready !== 1'b1) begin
            errors++;
            $display("FAIL join_ready: c1_rdy=%b c2_rdy=%b want 1 1", c1_ready, c2_ready);
        end
        @(posedge aclk);
        #1;
        c1_valid = 1'b0;
        c2_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 3'b001 || m_elem !== 3'b011) begin
            errors++;
            $display("FAIL join_beat: valid=%b y=%b elem=%b want 1 001 011",
                     m_valid, m_data, m_elem);
        end
        @(posedge aclk);
        #1;
        checks++;
        if (m_valid !== 1'b0 || dut.u_dwa.ptr_q !== 2'd2) begin
            errors++;
            $display("FAIL join_single: valid=%b ptr=%0d want 0 and 2", m_valid, dut.u_dwa.ptr_q);
        end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        m_ready = 1'b0;
        set_beat(1'b1, 1'b1);
        @(posedge aclk);
        #1;
        c1_valid = 1'b0;
        c2_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 3'b010) begin
            errors++;
            $display("FAIL rmid_pre: valid=%b y=%b want 1 010", m_valid, m_data);
        end
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || m_data !== 3'b000 || m_elem !== 3'b000) begin
            errors++;
            $display("FAIL rmid_async: valid=%b y=%b elem=%b want 0 000 000",
                     m_valid, m_data, m_elem);
        end
        @(negedge aclk);
        arst_n  = 1'b1;
        m_ready = 1'b1;
        set_beat(1'b0, 1'b0);
        @(posedge aclk);
        #1;
        c1_valid = 1'b0;
        c2_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_data !== 3'b000 || m_elem !== 3'b001 ||
            m_elem_s !== 3'b001) begin
            errors++;
            $display("FAIL rmid_post: valid=%b y=%b elem=%b static=%b want 1 000 001 001",
                     m_valid, m_data, m_elem, m_elem_s);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_join();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/axis_mash11_ncl.md
# axis_mash11_ncl

Noise-cancellation and element-selection stage of the MASH 1-1 DAC. Joins the 1-bit carry streams of the first and second `axis_efm` stages, forms the MASH 1-1 output y[n] = c1[n] + c2[n] − c2[n−1], and registers it as a signed 3-bit level. It also converts y into a 3-element unit-DAC drive word using data-weighted averaging (DWA) rotation. Sits directly downstream of the two cascaded EFM stages and feeds the output pin driver.

## Interface
- `N_ELEM`, 3, number of unit DAC elements; fixed at 3 because the output range is 4 levels.
- `DWA_EN`, 1, 1 = rotate element pointer (DWA); 0 = static thermometer from bit 0.
- `aclk` in 1: clock.
- `arst_n` in 1: reset; asynchronous, active-low; one clock domain only.
- `s_axis_c1_tdata` in 1: first-stage EFM carry.
- `s_axis_c1_tvalid` in 1; `s_axis_c1_tready` out 1.
- `s_axis_c2_tdata` in 1: second-stage EFM carry.
- `s_axis_c2_tvalid` in 1; `s_axis_c2_tready` out 1.
- `m_axis_data_tdata` out 3: signed level y, range −1..+2.
- `m_axis_elem_tdata` out N_ELEM: unit-element enables, popcount = y+1.
- `m_axis_data_tvalid` out 1: qualifies both master data words.
- `m_axis_data_tready` in 1.

## Operation
- Join: a beat is accepted only when `fire = c1_tvalid && c2_tvalid && (!m_tvalid || m_tready)`. Both `s_*_tready` equal `c_other_tvalid && (!m_tvalid || m_tready)`. Neither input is consumed alone.
- On fire:
  - y = c1 + c2 − c2_d, computed at 3-bit signed width.
  - c2_d ← c2.
  - count = y + 1 (0..3).
  - Output register ← (y, elem). `m_tvalid` ← 1.
- Without fire and with `m_tready`: `m_tvalid` ← 0.
- Holding: output data is stable while `m_tvalid && !m_tready`.
- DWA state ptr ∈ {0,1,2}:
  - elem sets bits ptr, ptr+1, … (count bits, indices mod 3).
  - ptr ← (ptr + count) mod 3. Wrap is exact; ptr never reaches 3.
  - count 0 → elem 000 and ptr unchanged. count 3 → elem 111 and ptr unchanged.
- DWA_EN=0: elem = (1<<count)−1 and ptr is held at 0.
- State (c2_d, ptr) advances only on fire. Stalls never corrupt the noise-shaping history.

## Timing
- Latency: 1 cycle from the accepted beat to `m_tvalid`.
- Throughput: 1 beat/cycle when `m_tready` is held high.
- Reset values:
  - `m_axis_data_tvalid`=0, `m_axis_data_tdata`=0, `m_axis_elem_tdata`=0.
  - `s_*_tready`=0.
  - c2_d=0, ptr=0.
- Reset mid-stream: an asserted `arst_n`=0 drops the pending output beat and clears history immediately (asynchronous). The first post-reset beat uses c2_d=0.
- Simultaneous output drain and new fire in one cycle: `m_tvalid` stays 1 and the register loads the new beat with no bubble.
- One input valid and the other not: no consumption. The waiting side's tready stays 0 until its partner is valid.

## Structure
- Package `mash_pkg`:
  - typedef `mash_level_t` (logic signed [2:0]).
  - constant `MASH_N_ELEM`=3.
  - function `level_to_count`.
- Sub-module `dwa_rotator`: holds ptr and maps count → elem, with an enable input equal to fire. This is the natural split; the join, difference and output register stay in the top.

## Test plan
- Reset release, both inputs idle → all outputs 0 and readies 0 for 10 cycles.
- Beats (c1,c2) = (1,1),(0,0),(1,0),(0,1), `m_tready`=1:
  - y = 2, −1, 1, 1.
  - elem = 111, 000, 011, 101.
  - Final ptr = 1.
- Same sequence with DWA_EN=0 → elem = 111, 000, 011, 011.
- `m_tready` low for 5 cycles after the first beat → output holds y=2 and elem=111, both readies stay 0, and c2_d is unchanged. The sequence resumes identically.
- c1 valid for 4 cycles, then c2 valid → no handshake until both are valid, then exactly one beat is consumed.
- `arst_n` pulsed low while `m_tvalid`=1 with c2_d=1 → outputs clear at once. The next beat (0,0) gives y=0, not −1.
